// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and sizing helper for the conv layer scheduler.
package conv_pkg;

   localparam int IMG_W  = 28;
   localparam int KER    = 3;
   localparam int CONV_W = IMG_W - KER + 1;
   localparam int PIXELS = IMG_W * IMG_W;
   localparam int POOL_N = (CONV_W / 2) * (CONV_W / 2);
   localparam int RES_W  = 21;
   localparam int ADDR_W = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_STREAM,
      S_COLLECT,
      S_NEXT,
      S_FINISH
   } sched_state_t;

   // pooled outputs per kernel for a square image after a valid conv and 2x2 pool
   function automatic int pool_count(input int img_w, input int ker);
      int half;
      half = (img_w - ker + 1) / 2;
      return half * half;
   endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Image RAM address generator: restarted by the engine start pulse, walks 1..NPIX-1
// and raises last one cycle after the final address, when the last pixel is at the engine.
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int NPIX = PIXELS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic [ADDR_W-1:0] img_addr_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              run_q, run_d;
   logic              last_q, last_d;

   always_comb begin
      pix_cnt_d = pix_cnt_q;
      run_d     = run_q;
      last_d    = 1'b0;
      if (start_i) begin
         // address 0 is already on the bus during the start cycle
         pix_cnt_d = ADDR_W'(1);
         run_d     = 1'b1;
      end else if (run_q) begin
         if (pix_cnt_q == ADDR_W'(NPIX - 1)) begin
            pix_cnt_d = '0;
            run_d     = 1'b0;
            last_d    = 1'b1;
         end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pix_cnt_q <= '0;
         run_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         pix_cnt_q <= pix_cnt_d;
         run_q     <= run_d;
         last_q    <= last_d;
      end
   end

   assign img_addr_o = pix_cnt_q;
   assign last_o     = last_q;

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler for the 3x3 conv + 2x2 max-pool engine: one job runs every kernel in turn.
// Optional COLLECT watchdog is enabled by defining CONV_SCHED_WDOG_EN.
//
// state   | meaning
// IDLE    | waiting for a job, job_ready high
// START   | one-cycle engine start, kernel selected, image address 0 issued
// STREAM  | image addresses 1..PIXELS-1 issued, then the last pixel drains
// COLLECT | pooled results written to the feature-map buffer until eng_done
// NEXT    | advance to the next kernel or finish the layer
// FINISH  | layer_done pulse
module conv_layer_sched
   import conv_pkg::*;
#(
   parameter int IMG_W    = conv_pkg::IMG_W,
   parameter int KER      = conv_pkg::KER,
   parameter int NUM_FILT = 4,
   parameter int RES_W    = conv_pkg::RES_W,
   parameter int TIMEOUT  = 4095
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          job_valid,
   output logic                                          job_ready,
   output logic [ADDR_W-1:0]                             img_addr,
   input  logic [7:0]                                    img_data,
   output logic                                          eng_start,
   output logic [7:0]                                    eng_pixel,
   output logic [((NUM_FILT > 1) ? $clog2(NUM_FILT) : 1)-1:0] ker_sel,
   input  logic                                          eng_pool_valid,
   input  logic [RES_W-1:0]                              eng_result,
   input  logic                                          eng_done,
   output logic                                          fm_we,
   output logic [ADDR_W-1:0]                             fm_addr,
   output logic [RES_W-1:0]                              fm_data,
   output logic                                          busy,
   output logic                                          layer_done,
   output logic                                          err
);

   localparam int PIX_N  = IMG_W * IMG_W;
   localparam int POOL_C = pool_count(IMG_W, KER);
   localparam int FILT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
   localparam int RC_W   = $clog2(POOL_C + 1);

   if (NUM_FILT < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("conv_layer_sched: NUM_FILT and TIMEOUT must be at least 1");
   end

   sched_state_t      state_q, state_d;
   logic [FILT_W-1:0] filt_q, filt_d;
   logic [RC_W-1:0]   res_cnt_q, res_cnt_d;
   logic              err_q, err_d;
   logic              eng_start_q, eng_start_d;
   logic              busy_q, busy_d;
   logic              job_ready_q, job_ready_d;
   logic              layer_done_q, layer_done_d;
   logic              fm_we_q, fm_we_d;
   logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
   logic [RES_W-1:0]  fm_data_q, fm_data_d;
   logic              addr_last;
   logic              wd_expire;
   logic              accept;
   logic              wr_ok;

   conv_addr_gen #(
      .NPIX (PIX_N)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .start_i    (eng_start_q),
      .img_addr_o (img_addr),
      .last_o     (addr_last)
   );

`ifdef CONV_SCHED_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   // down-counter preloaded outside COLLECT, so it starts fresh on every entry
   always_comb begin
      wd_d = wd_q;
      if (state_q != S_COLLECT) begin
         wd_d = WD_W'(TIMEOUT - 1);
      end else if (wd_q != '0) begin
         wd_d = wd_q - WD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_q <= WD_W'(TIMEOUT - 1);
      end else begin
         wd_q <= wd_d;
      end
   end

   assign wd_expire = (state_q == S_COLLECT) && !eng_done && (wd_q == '0);
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (job_valid) state_d = S_START;
         S_START:   state_d = S_STREAM;
         S_STREAM:  if (addr_last) state_d = S_COLLECT;
         S_COLLECT: begin
            if (eng_done) begin
               state_d = S_NEXT;
            end else if (wd_expire) begin
               state_d = S_IDLE;
            end
         end
         S_NEXT:    state_d = (filt_q == FILT_W'(NUM_FILT - 1)) ? S_FINISH : S_START;
         S_FINISH:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      filt_d    = filt_q;
      res_cnt_d = res_cnt_q;
      err_d     = err_q;
      fm_we_d   = 1'b0;
      fm_addr_d = fm_addr_q;
      fm_data_d = fm_data_q;
      accept    = (state_q == S_IDLE) && job_valid;
      wr_ok     = (state_q == S_COLLECT) && eng_pool_valid && (res_cnt_q < RC_W'(POOL_C));

      if (accept) begin
         filt_d    = '0;
         res_cnt_d = '0;
         err_d     = 1'b0;
      end
      if (wr_ok) begin
         fm_we_d   = 1'b1;
         fm_data_d = eng_result;
         fm_addr_d = ADDR_W'(filt_q) * ADDR_W'(POOL_C) + ADDR_W'(res_cnt_q);
         res_cnt_d = res_cnt_q + RC_W'(1);
      end
      // a write landing with eng_done is already included in res_cnt_d
      if ((state_q == S_COLLECT) && eng_done && (res_cnt_d != RC_W'(POOL_C))) begin
         err_d = 1'b1;
      end
      if ((state_q != S_COLLECT) && (eng_pool_valid || eng_done)) begin
         err_d = 1'b1;
      end
      if (wd_expire) begin
         err_d = 1'b1;
      end
      if ((state_q == S_NEXT) && (state_d == S_START)) begin
         filt_d    = filt_q + FILT_W'(1);
         res_cnt_d = '0;
      end

      eng_start_d  = (state_d == S_START);
      busy_d       = (state_d != S_IDLE);
      job_ready_d  = (state_d == S_IDLE);
      layer_done_d = (state_d == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         filt_q       <= '0;
         res_cnt_q    <= '0;
         err_q        <= 1'b0;
         eng_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         job_ready_q  <= 1'b1;
         layer_done_q <= 1'b0;
         fm_we_q      <= 1'b0;
         fm_addr_q    <= '0;
         fm_data_q    <= '0;
      end else begin
         filt_q       <= filt_d;
         res_cnt_q    <= res_cnt_d;
         err_q        <= err_d;
         eng_start_q  <= eng_start_d;
         busy_q       <= busy_d;
         job_ready_q  <= job_ready_d;
         layer_done_q <= layer_done_d;
         fm_we_q      <= fm_we_d;
         fm_addr_q    <= fm_addr_d;
         fm_data_q    <= fm_data_d;
      end
   end

   assign job_ready  = job_ready_q;
   assign eng_start  = eng_start_q;
   assign eng_pixel  = img_data;
   assign ker_sel    = filt_q;
   assign fm_we      = fm_we_q;
   assign fm_addr    = fm_addr_q;
   assign fm_data    = fm_data_q;
   assign busy       = busy_q;
   assign layer_done = layer_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: a four-kernel instance driven by a behavioural engine and
// image RAM, plus a one-kernel instance for the single-filter run or the COLLECT watchdog.
module tb_conv_layer_sched;
   import conv_pkg::*;

   localparam int NF = 4;
   localparam int PN = 169;
   localparam int NP = 784;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;
   typedef int nv_t [NF];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        job_valid, job_ready, eng_start, eng_pool_valid, eng_done;
   logic        fm_we, busy, layer_done, err;
   logic [9:0]  img_addr, fm_addr;
   logic [7:0]  img_data, eng_pixel;
   logic [1:0]  ker_sel;
   logic [20:0] eng_result, fm_data;

   logic        s_job_valid, s_job_ready, s_eng_start, s_pool_valid, s_done;
   logic        s_fm_we, s_busy, s_layer_done, s_err;
   logic [9:0]  s_img_addr, s_fm_addr;
   logic [7:0]  s_img_data, s_eng_pixel;
   logic [0:0]  s_ker_sel;
   logic [20:0] s_result, s_fm_data;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   wr_t exp_q[$];
   wr_t s_log[$];
   int  wr_log[$];
   wr_t cmp_e;

   conv_layer_sched #(.NUM_FILT(NF)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .img_addr(img_addr), .img_data(img_data), .eng_start(eng_start),
      .eng_pixel(eng_pixel), .ker_sel(ker_sel), .eng_pool_valid(eng_pool_valid),
      .eng_result(eng_result), .eng_done(eng_done), .fm_we(fm_we), .fm_addr(fm_addr),
      .fm_data(fm_data), .busy(busy), .layer_done(layer_done), .err(err)
   );

   conv_layer_sched #(.NUM_FILT(1), .TIMEOUT(50)) dut1 (
      .clk(clk), .rst(rst), .job_valid(s_job_valid), .job_ready(s_job_ready),
      .img_addr(s_img_addr), .img_data(s_img_data), .eng_start(s_eng_start),
      .eng_pixel(s_eng_pixel), .ker_sel(s_ker_sel), .eng_pool_valid(s_pool_valid),
      .eng_result(s_result), .eng_done(s_done), .fm_we(s_fm_we), .fm_addr(s_fm_addr),
      .fm_data(s_fm_data), .busy(s_busy), .layer_done(s_layer_done), .err(s_err)
   );

   // image RAM holding addr & 0xFF, one-cycle read latency
   always @(posedge clk) begin
      img_data   <= img_addr[7:0];
      s_img_data <= s_img_addr[7:0];
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // every-cycle compare against the expected-write queue filled by the engine model
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("ready_vs_busy", job_ready, !busy);
         if (fm_we === 1'b1) begin
            wr_log.push_back(int'(fm_addr));
            if (exp_q.size() == 0) begin
               chk("fm_extra_write", exp_q.size(), 1);
            end else begin
               cmp_e = exp_q.pop_front();
               chk("fm_addr", fm_addr, cmp_e.addr);
               chk("fm_data", fm_data, cmp_e.data);
               chk("fm_latency", cyc, cmp_e.cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1 && s_fm_we === 1'b1) begin
         s_log.push_back('{cyc, int'(s_fm_addr), int'(s_fm_data)});
      end
   end

   task automatic run_filter(input int f, input int nval, input bit done_last,
                             input int go_cyc, input int lat, output int done_cyc);
      int  t;
      int  mism;
      wr_t e;
      t = 0;
      while (eng_start !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("start_seen", t < 2000, 1);
      chk("start_latency", cyc - go_cyc, lat);
      chk("ker_sel", ker_sel, f);
      mism = 0;
      for (int k = 0; k < NP; k++) begin
         @(negedge clk);
         if (eng_pixel !== 8'(k) || eng_start !== 1'b0) mism++;
      end
      chk("stream_pixels", mism, 0);
      @(negedge clk);
      chk("collect_busy", busy, 1);
      for (int i = 0; i < nval; i++) begin
         eng_pool_valid = 1'b1;
         eng_result     = 21'(f * 4096 + i * 7 + 3);
         eng_done       = done_last && (i == nval - 1);
         if (i < PN) begin
            e.cyc  = cyc + 1;
            e.addr = f * PN + i;
            e.data = f * 4096 + i * 7 + 3;
            exp_q.push_back(e);
         end
         @(negedge clk);
      end
      eng_pool_valid = 1'b0;
      if (!done_last) begin
         eng_done = 1'b1;
         @(negedge clk);
      end
      eng_done = 1'b0;
      done_cyc = cyc - 1;
      chk("next_no_layer_done", layer_done, 0);
   endtask

   task automatic run_job(input nv_t nv, input bit exp_err);
      int go;
      int d;
      wr_log.delete();
      job_valid = 1'b1;
      go = cyc;
      @(negedge clk);
      job_valid = 1'b0;
      chk("err_clear_on_accept", err, 0);
      for (int f = 0; f < NF; f++) begin
         // a request held while busy must not restart the layer
         if (f == 1) job_valid = 1'b1;
         run_filter(f, nv[f], (f % 2) == 0, go, (f == 0) ? 1 : 2, d);
         job_valid = 1'b0;
         go = d;
      end
      @(negedge clk);
      chk("layer_done_pulse", layer_done, 1);
      chk("finish_busy", busy, 1);
      @(negedge clk);
      chk("layer_done_single", layer_done, 0);
      chk("idle_ready", job_ready, 1);
      chk("layer_err", err, exp_err);
      chk("fm_missing", exp_q.size(), 0);
   endtask

   task automatic single_run();
      int mism;
      int ld;
      s_log.delete();
      s_job_valid = 1'b1;
      @(negedge clk);
      s_job_valid = 1'b0;
      chk("s_start", s_eng_start, 1);
      chk("s_ker_sel", s_ker_sel, 0);
      repeat (785) @(negedge clk);
`ifdef CONV_SCHED_WDOG_EN
      repeat (49) @(negedge clk);
      chk("wd_err_before", s_err, 0);
      chk("wd_busy_before", s_busy, 1);
      @(negedge clk);
      chk("wd_err_after", s_err, 1);
      chk("wd_idle", s_job_ready, 1);
      chk("wd_not_busy", s_busy, 0);
      ld = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (s_layer_done === 1'b1) ld++;
      end
      chk("wd_no_layer_done", ld, 0);
      chk("wd_no_writes", s_log.size(), 0);
`else
      for (int i = 0; i < PN; i++) begin
         s_pool_valid = 1'b1;
         s_result     = 21'(i + 100);
         s_done       = (i == PN - 1);
         @(negedge clk);
      end
      s_pool_valid = 1'b0;
      s_done       = 1'b0;
      chk("s_next_no_done", s_layer_done, 0);
      @(negedge clk);
      chk("s_layer_done", s_layer_done, 1);
      @(negedge clk);
      ld = int'(s_layer_done);
      chk("s_layer_done_single", ld, 0);
      chk("s_err", s_err, 0);
      chk("s_idle", s_job_ready, 1);
      chk("s_write_count", s_log.size(), 169);
      mism = 0;
      foreach (s_log[i]) begin
         if (s_log[i].addr != i || s_log[i].data != i + 100) mism++;
      end
      chk("s_write_content", mism, 0);
      if (s_log.size() == 169) chk("s_last_addr", s_log[168].addr, 168);
`endif
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: got cycle %0d required finish", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      nv_t nv;
      rst = 1'b0;
      job_valid = 1'b0; eng_pool_valid = 1'b0; eng_done = 1'b0; eng_result = '0;
      s_job_valid = 1'b0; s_pool_valid = 1'b0; s_done = 1'b0; s_result = '0;
      repeat (3) @(negedge clk);
      chk("rst_job_ready", job_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_fm_we", fm_we, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_err", err, 0);
      chk("rst_img_addr", img_addr, 0);
      chk("rst_fm_addr", fm_addr, 0);
      chk("rst_fm_data", fm_data, 0);
      chk("rst_ker_sel", ker_sel, 0);
      chk("rst_s_job_ready", s_job_ready, 1);
      rst = 1'b1;
      @(negedge clk);

      single_run();

      nv = '{169, 169, 169, 169};
      run_job(nv, 1'b0);
      chk("a_write_count", wr_log.size(), 676);
      if (wr_log.size() == 676) begin
         chk("a_f2_first", wr_log[338], 338);
         chk("a_f2_last", wr_log[506], 506);
         chk("a_last", wr_log[675], 675);
      end

      eng_pool_valid = 1'b1;
      @(negedge clk);
      eng_pool_valid = 1'b0;
      @(negedge clk);
      chk("stray_valid_err", err, 1);

      nv = '{171, 169, 170, 169};
      run_job(nv, 1'b0);
      chk("b_write_count", wr_log.size(), 676);

      nv = '{169, 168, 169, 169};
      run_job(nv, 1'b1);
      chk("c_write_count", wr_log.size(), 675);
      if (wr_log.size() == 675) chk("c_f2_first", wr_log[337], 338);

      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      repeat (401) @(negedge clk);
      chk("pixel_400", eng_pixel, 144);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", job_ready, 1);
      chk("mid_rst_fm_we", fm_we, 0);
      chk("mid_rst_start", eng_start, 0);
      chk("mid_rst_img_addr", img_addr, 0);
      rst = 1'b1;
      @(negedge clk);

      nv = '{169, 169, 169, 169};
      run_job(nv, 1'b0);
      chk("d_write_count", wr_log.size(), 676);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
